// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-level UART transmitter between four packet requesters.
// Optional macro UART_ARB_TAG_EN: prefix every packet with a source tag byte (TAG_BASE | index).
module uart_tx_arbiter #(
  parameter logic [15:0] GAP_TIMEOUT = 16'd52080
`ifdef UART_ARB_TAG_EN
  , parameter logic [7:0] TAG_BASE = 8'hA0
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [3:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_DATA = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  grant_q;
  logic [1:0]  g_q;
  logic [1:0]  last_grant_q;
  logic [15:0] gap_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        last_r_q;
  logic        timeout_q;

  logic [1:0]  pick_s;
  logic        upstream_s;
  logic        downstream_s;

  // First valid requester after the last one served, so the just-served index ranks lowest.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign pick_s       = rr_pick(req_valid, last_grant_q);
  assign req_ready    = (state_q == S_DATA && !tx_valid_q) ? grant_q : 4'b0000;
  assign upstream_s   = |(req_valid & req_ready);
  assign downstream_s = tx_valid_q & tx_data_ready;

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign grant         = grant_q;
  assign timeout_err   = timeout_q;

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 4'b0000;
      g_q          <= 2'd0;
      last_grant_q <= 2'd3;
      gap_q        <= 16'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      last_r_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          grant_q <= 4'b0000;
          if (|req_valid) begin
            g_q     <= pick_s;
            grant_q <= onehot(pick_s);
            gap_q   <= 16'd0;
`ifdef UART_ARB_TAG_EN
            state_q <= S_TAG;
`else
            state_q <= S_DATA;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        // The tag is loaded on entry and held until the serialiser takes it.
        S_TAG: begin
          if (!tx_valid_q) begin
            tx_data_q  <= TAG_BASE | {6'd0, g_q};
            tx_valid_q <= 1'b1;
          end else if (tx_data_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_DATA;
          end
        end
`endif
        S_DATA: begin
          if (upstream_s) begin
            tx_data_q  <= req_data[{g_q, 3'b000} +: 8];
            tx_valid_q <= 1'b1;
            last_r_q   <= req_last[g_q];
            gap_q      <= 16'd0;
            state_q    <= S_WAIT;
          end else if (!req_valid[g_q]) begin
            if (gap_q == GAP_TIMEOUT - 16'd1) begin
              timeout_q    <= 1'b1;
              grant_q      <= 4'b0000;
              last_grant_q <= g_q;
              gap_q        <= 16'd0;
              state_q      <= S_IDLE;
            end else begin
              gap_q <= gap_q + 16'd1;
            end
          end
        end
        S_WAIT: begin
          if (downstream_s) begin
            tx_valid_q <= 1'b0;
            if (last_r_q) begin
              grant_q      <= 4'b0000;
              last_grant_q <= g_q;
              state_q      <= S_IDLE;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          grant_q    <= 4'b0000;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
